// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Two-requester pipelined Wishbone arbiter with an outstanding-request cap and
// an ordered drain phase before the bus can change hands.
// Rev     : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int ADDR_BITS       = 23,
  parameter int BYTES           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   sresetn,

  input  logic                   s0_wb_cyc,
  input  logic                   s0_wb_stb,
  input  logic                   s0_wb_we,
  input  logic [ADDR_BITS-1:0]   s0_wb_addr,
  input  logic [BYTES*8-1:0]     s0_wb_dat_m2s,
  input  logic [BYTES-1:0]       s0_wb_sel,
  output logic                   s0_wb_ack,
  output logic                   s0_wb_stall,
  output logic [BYTES*8-1:0]     s0_wb_dat_s2m,

  input  logic                   s1_wb_cyc,
  input  logic                   s1_wb_stb,
  input  logic                   s1_wb_we,
  input  logic [ADDR_BITS-1:0]   s1_wb_addr,
  input  logic [BYTES*8-1:0]     s1_wb_dat_m2s,
  input  logic [BYTES-1:0]       s1_wb_sel,
  output logic                   s1_wb_ack,
  output logic                   s1_wb_stall,
  output logic [BYTES*8-1:0]     s1_wb_dat_s2m,

  output logic                   m_wb_cyc,
  output logic                   m_wb_stb,
  output logic                   m_wb_we,
  output logic [ADDR_BITS-1:0]   m_wb_addr,
  output logic [BYTES*8-1:0]     m_wb_dat_m2s,
  output logic [BYTES-1:0]       m_wb_sel,
  input  logic                   m_wb_ack,
  input  logic                   m_wb_stall,
  input  logic [BYTES*8-1:0]     m_wb_dat_s2m,

  output logic                   err_spurious_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN0  = 2'd1;
  localparam logic [1:0] ST_OWN1  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] outstanding_q, outstanding_d;
  logic       err_spurious_q, err_spurious_d;

  logic       owner_is_s1;
  logic       owner_cyc;
  logic       at_cap;
  logic       ack_valid;
  logic       accept;

  always_comb begin
    owner_is_s1 = (state_q == ST_OWN1);
    owner_cyc   = owner_is_s1 ? s1_wb_cyc : s0_wb_cyc;
    at_cap      = (outstanding_q == MAX_OUT);
    // An ack with nothing in flight is neither counted nor forwarded.
    ack_valid   = m_wb_ack && (outstanding_q != 4'd0);
    accept      = m_wb_stb && !m_wb_stall;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      outstanding_q  <= 4'd0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      outstanding_q  <= outstanding_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    outstanding_d  = outstanding_q + {3'd0, accept} - {3'd0, ack_valid};
    err_spurious_d = err_spurious_q | (m_wb_ack && (outstanding_q == 4'd0));
    case (state_q)
      ST_IDLE: begin
        if (s0_wb_cyc && s1_wb_cyc) begin
          last_grant_d = ~last_grant_q;
          state_d      = last_grant_q ? ST_OWN0 : ST_OWN1;
        end else if (s0_wb_cyc) begin
          last_grant_d = 1'b0;
          state_d      = ST_OWN0;
        end else if (s1_wb_cyc) begin
          last_grant_d = 1'b1;
          state_d      = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!owner_cyc) begin
          state_d = (outstanding_d == 4'd0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_d == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_wb_cyc     = 1'b0;
    m_wb_stb     = 1'b0;
    m_wb_we      = owner_is_s1 ? s1_wb_we      : s0_wb_we;
    m_wb_addr    = owner_is_s1 ? s1_wb_addr    : s0_wb_addr;
    m_wb_dat_m2s = owner_is_s1 ? s1_wb_dat_m2s : s0_wb_dat_m2s;
    m_wb_sel     = owner_is_s1 ? s1_wb_sel     : s0_wb_sel;
    s0_wb_stall  = 1'b1;
    s1_wb_stall  = 1'b1;
    s0_wb_ack    = 1'b0;
    s1_wb_ack    = 1'b0;
    case (state_q)
      ST_OWN0: begin
        m_wb_cyc    = 1'b1;
        m_wb_stb    = s0_wb_cyc && s0_wb_stb && !at_cap;
        s0_wb_stall = m_wb_stall || at_cap;
        s0_wb_ack   = ack_valid;
      end
      ST_OWN1: begin
        m_wb_cyc    = 1'b1;
        m_wb_stb    = s1_wb_cyc && s1_wb_stb && !at_cap;
        s1_wb_stall = m_wb_stall || at_cap;
        s1_wb_ack   = ack_valid;
      end
      ST_DRAIN: begin
        // Remaining acks belong to whoever owned the bus last.
        m_wb_cyc = 1'b1;
        if (last_grant_q) begin
          s1_wb_ack = ack_valid;
        end else begin
          s0_wb_ack = ack_valid;
        end
      end
      default: ;
    endcase
  end

  assign s0_wb_dat_s2m    = m_wb_dat_s2m;
  assign s1_wb_dat_s2m    = m_wb_dat_s2m;
  assign err_spurious_ack = err_spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// tb_wb_arbiter: directed scenarios followed by randomized traffic, every cycle
// compared against a queue-based model of who owns each in-flight request.
module tb_wb_arbiter;
  localparam int AB   = 23;
  localparam int NB   = 2;
  localparam int DB   = 16;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sresetn;
  logic          s0_wb_cyc, s0_wb_stb, s0_wb_we;
  logic [AB-1:0] s0_wb_addr;
  logic [DB-1:0] s0_wb_dat_m2s;
  logic [NB-1:0] s0_wb_sel;
  logic          s0_wb_ack, s0_wb_stall;
  logic [DB-1:0] s0_wb_dat_s2m;
  logic          s1_wb_cyc, s1_wb_stb, s1_wb_we;
  logic [AB-1:0] s1_wb_addr;
  logic [DB-1:0] s1_wb_dat_m2s;
  logic [NB-1:0] s1_wb_sel;
  logic          s1_wb_ack, s1_wb_stall;
  logic [DB-1:0] s1_wb_dat_s2m;
  logic          m_wb_cyc, m_wb_stb, m_wb_we;
  logic [AB-1:0] m_wb_addr;
  logic [DB-1:0] m_wb_dat_m2s;
  logic [NB-1:0] m_wb_sel;
  logic          m_wb_ack, m_wb_stall;
  logic [DB-1:0] m_wb_dat_s2m;
  logic          err_spurious_ack;

  wb_arbiter #(.ADDR_BITS(AB), .BYTES(NB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .sresetn(sresetn),
    .s0_wb_cyc(s0_wb_cyc), .s0_wb_stb(s0_wb_stb), .s0_wb_we(s0_wb_we),
    .s0_wb_addr(s0_wb_addr), .s0_wb_dat_m2s(s0_wb_dat_m2s), .s0_wb_sel(s0_wb_sel),
    .s0_wb_ack(s0_wb_ack), .s0_wb_stall(s0_wb_stall), .s0_wb_dat_s2m(s0_wb_dat_s2m),
    .s1_wb_cyc(s1_wb_cyc), .s1_wb_stb(s1_wb_stb), .s1_wb_we(s1_wb_we),
    .s1_wb_addr(s1_wb_addr), .s1_wb_dat_m2s(s1_wb_dat_m2s), .s1_wb_sel(s1_wb_sel),
    .s1_wb_ack(s1_wb_ack), .s1_wb_stall(s1_wb_stall), .s1_wb_dat_s2m(s1_wb_dat_s2m),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
    .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_sel(m_wb_sel),
    .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall), .m_wb_dat_s2m(m_wb_dat_s2m),
    .err_spurious_ack(err_spurious_ack)
  );

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 = nobody owns, 1 = 'who' owns, 2 = finishing 'who' acks.
  int mode, who, last;
  bit err_m;
  int q[$];   // requester id of each accepted, not yet acked request
  bit e_stb, e_stall0, e_stall1, e_ack0, e_ack1, e_ackok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit oc, os, cap;
    cap      = (q.size() == MAXO);
    e_stb    = 1'b0;
    e_stall0 = 1'b1;
    e_stall1 = 1'b1;
    if (mode == 1) begin
      oc    = (who == 0) ? s0_wb_cyc : s1_wb_cyc;
      os    = (who == 0) ? s0_wb_stb : s1_wb_stb;
      e_stb = oc && os && !cap;
      if (who == 0) e_stall0 = m_wb_stall || cap;
      else          e_stall1 = m_wb_stall || cap;
    end
    e_ackok = m_wb_ack && (q.size() > 0);
    e_ack0  = 1'b0;
    e_ack1  = 1'b0;
    if (e_ackok) begin
      if (q[0] == 0) e_ack0 = 1'b1;
      else           e_ack1 = 1'b1;
    end
    chk("m_cyc", m_wb_cyc, (mode != 0));
    chk("m_stb", m_wb_stb, e_stb);
    chk("s0_stall", s0_wb_stall, e_stall0);
    chk("s1_stall", s1_wb_stall, e_stall1);
    chk("s0_ack", s0_wb_ack, e_ack0);
    chk("s1_ack", s1_wb_ack, e_ack1);
    chk("err_flag", err_spurious_ack, err_m);
    chk("s0_dat_s2m", s0_wb_dat_s2m, m_wb_dat_s2m);
    chk("s1_dat_s2m", s1_wb_dat_s2m, m_wb_dat_s2m);
    chk("outstanding", dut.outstanding_q, q.size());
    if (mode == 1) begin
      chk("m_we",   m_wb_we,      (who == 0) ? s0_wb_we      : s1_wb_we);
      chk("m_addr", m_wb_addr,    (who == 0) ? s0_wb_addr    : s1_wb_addr);
      chk("m_dat",  m_wb_dat_m2s, (who == 0) ? s0_wb_dat_m2s : s1_wb_dat_m2s);
      chk("m_sel",  m_wb_sel,     (who == 0) ? s0_wb_sel     : s1_wb_sel);
    end
  endtask

  task automatic model_edge();
    if (!sresetn) begin
      mode = 0; q.delete(); last = 1; err_m = 1'b0;
      return;
    end
    if (m_wb_ack && q.size() == 0) err_m = 1'b1;
    if (e_ackok) void'(q.pop_front());
    if (e_stb && !m_wb_stall) q.push_back(who);
    case (mode)
      0: begin
        if (s0_wb_cyc && s1_wb_cyc) begin who = 1 - last; mode = 1; last = who; end
        else if (s0_wb_cyc)         begin who = 0; mode = 1; last = 0; end
        else if (s1_wb_cyc)         begin who = 1; mode = 1; last = 1; end
      end
      1: if (!((who == 0) ? s0_wb_cyc : s1_wb_cyc)) mode = (q.size() == 0) ? 0 : 2;
      default: if (q.size() == 0) mode = 0;
    endcase
  endtask

  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    s0_wb_cyc = 0; s0_wb_stb = 0; s0_wb_we = 0;
    s1_wb_cyc = 0; s1_wb_stb = 0; s1_wb_we = 0;
    m_wb_ack = 0; m_wb_stall = 0;
  endtask

  task automatic rand_payload();
    s0_wb_addr = AB'($urandom()); s0_wb_dat_m2s = DB'($urandom()); s0_wb_sel = NB'($urandom());
    s1_wb_addr = AB'($urandom()); s1_wb_dat_m2s = DB'($urandom()); s1_wb_sel = NB'($urandom());
    m_wb_dat_s2m = DB'($urandom());
  endtask

  task automatic drain_to_idle(input string tag);
    quiet();
    for (int i = 0; i < 20 && mode != 0; i++) begin
      m_wb_ack = (q.size() > 0);
      cycle();
    end
    m_wb_ack = 0;
    #1;
    chk(tag, m_wb_cyc, 1'b0);
  endtask

  initial begin
    int n;
    mode = 0; who = 0; last = 1; err_m = 1'b0;
    sresetn = 1'b0;
    quiet();
    rand_payload();
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    cycle();
    sresetn = 1'b1;

    // Tie after reset goes to s0, then s1, then s0 again.
    s0_wb_cyc = 1; s1_wb_cyc = 1;
    cycle();
    #1;
    chk("tie1_s0_grant", s0_wb_stall, 1'b0);
    chk("tie1_s1_blocked", s1_wb_stall, 1'b1);
    s0_wb_cyc = 0;
    cycle();
    #1;
    chk("tie_idle_between", m_wb_cyc, 1'b0);
    cycle();
    #1;
    chk("tie2_s1_grant", s1_wb_stall, 1'b0);
    s1_wb_cyc = 0;
    cycle();
    s0_wb_cyc = 1; s1_wb_cyc = 1;
    cycle();
    #1;
    chk("tie3_s0_grant", s0_wb_stall, 1'b0);
    quiet();
    cycle();

    // Outstanding cap.
    s0_wb_cyc = 1;
    cycle();
    s0_wb_stb = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      rand_payload();
      #1;
      if (m_wb_stb && !m_wb_stall) n++;
      cycle();
    end
    chk("cap_accepts", n, 4);
    #1;
    chk("cap_stall", s0_wb_stall, 1'b1);
    m_wb_ack = 1;
    #1;
    chk("cap_stall_on_ack", s0_wb_stall, 1'b1);
    chk("cap_nostb_on_ack", m_wb_stb, 1'b0);
    cycle();
    m_wb_ack = 0;
    #1;
    chk("cap_reaccept", m_wb_stb, 1'b1);
    cycle();
    #1;
    chk("cap_stall_again", s0_wb_stall, 1'b1);
    drain_to_idle("cap_drain_idle");

    // Accept and ack in the same cycle at two outstanding.
    s0_wb_cyc = 1;
    cycle();
    s0_wb_stb = 1;
    cycle();
    cycle();
    m_wb_ack = 1;
    #1;
    chk("accack_stb", m_wb_stb, 1'b1);
    cycle();
    chk("accack_outstanding", dut.outstanding_q, 4'd2);
    drain_to_idle("accack_drain_idle");

    // s1 writes three times then leaves; s0 waits through the drain.
    s1_wb_cyc = 1;
    cycle();
    s1_wb_stb = 1; s1_wb_we = 1;
    cycle(); cycle(); cycle();
    s1_wb_cyc = 0; s1_wb_stb = 0; s1_wb_we = 0;
    s0_wb_cyc = 1; s0_wb_stb = 1;
    cycle();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      m_wb_ack = 1;
      #1;
      chk("drain_cyc", m_wb_cyc, 1'b1);
      chk("drain_s0_stall", s0_wb_stall, 1'b1);
      chk("drain_s0_ack", s0_wb_ack, 1'b0);
      if (s1_wb_ack) n++;
      cycle();
    end
    m_wb_ack = 0;
    chk("drain_s1_acks", n, 3);
    #1;
    chk("drain_idle", m_wb_cyc, 1'b0);
    cycle();
    drain_to_idle("drain_s0_idle");

    // Spurious ack while idle.
    quiet();
    m_wb_ack = 1;
    #1;
    chk("spur_s0_ack", s0_wb_ack, 1'b0);
    chk("spur_s1_ack", s1_wb_ack, 1'b0);
    cycle();
    m_wb_ack = 0;
    cycle(); cycle();
    #1;
    chk("spur_sticky", err_spurious_ack, 1'b1);
    sresetn = 1'b0;
    cycle();
    sresetn = 1'b1;
    #1;
    chk("spur_cleared", err_spurious_ack, 1'b0);

    // Reset in the middle of a transaction with three outstanding.
    s0_wb_cyc = 1;
    cycle();
    s0_wb_stb = 1;
    cycle(); cycle(); cycle();
    s0_wb_stb = 0;
    #1;
    chk("midrst_outstanding3", dut.outstanding_q, 4'd3);
    sresetn = 1'b0;
    cycle();
    #1;
    chk("midrst_cyc", m_wb_cyc, 1'b0);
    chk("midrst_outstanding0", dut.outstanding_q, 4'd0);
    chk("midrst_stall", s0_wb_stall, 1'b1);
    sresetn = 1'b1;
    quiet();
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (s0_wb_cyc) begin if ($urandom_range(0, 9) == 0) s0_wb_cyc = 0; end
      else if ($urandom_range(0, 5) == 0) s0_wb_cyc = 1;
      if (s1_wb_cyc) begin if ($urandom_range(0, 9) == 0) s1_wb_cyc = 0; end
      else if ($urandom_range(0, 5) == 0) s1_wb_cyc = 1;
      s0_wb_stb  = s0_wb_cyc && ($urandom_range(0, 9) < 7);
      s1_wb_stb  = s1_wb_cyc && ($urandom_range(0, 9) < 7);
      s0_wb_we   = 1'($urandom());
      s1_wb_we   = 1'($urandom());
      m_wb_stall = ($urandom_range(0, 3) == 0);
      m_wb_ack   = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      sresetn    = ($urandom_range(0, 299) != 0);
      rand_payload();
      cycle();
    end

    quiet();
    sresetn = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 23, Wishbone word-address width.
REQ-002 SHALL have parameter BYTES, default 2, data bus width in bytes; select width is BYTES.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, cap on accepted-but-unacked requests; range 1..15.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port sresetn, input, 1, synchronous active-low reset.
REQ-006 SHALL have, for each requester n in {0,1}: sn_wb_cyc/stb/we, input, 1 each; sn_wb_addr, input, ADDR_BITS; sn_wb_dat_m2s, input, BYTES*8; sn_wb_sel, input, BYTES.
REQ-007 SHALL have, for each requester n: sn_wb_ack, output, 1; sn_wb_stall, output, 1; sn_wb_dat_s2m, output, BYTES*8.
REQ-008 SHALL have downstream m_wb_cyc/stb/we, output, 1 each; m_wb_addr, output, ADDR_BITS; m_wb_dat_m2s, output, BYTES*8; m_wb_sel, output, BYTES.
REQ-009 SHALL have downstream m_wb_ack, input, 1; m_wb_stall, input, 1; m_wb_dat_s2m, input, BYTES*8.
REQ-010 SHALL have err_spurious_ack, output, 1, sticky flag for ack received with zero outstanding.

Function
REQ-011 SHALL implement pipelined Wishbone: a request is accepted in any cycle with stb=1 and stall=0; acks return in request order.
REQ-012 SHALL hold a registered FSM with states IDLE, OWN0, OWN1, DRAIN, plus registered last_grant (1 bit) and outstanding count (4 bits).
REQ-013 SHALL in IDLE: if exactly one sn_wb_cyc=1, go to OWNn next cycle; if both, go to OWN of requester != last_grant; update last_grant to the winner.
REQ-014 SHALL in OWNn pass sn_wb_stb/we/addr/dat_m2s/sel combinationally to m_wb_*, drive m_wb_cyc=1, route m_wb_stall to sn_wb_stall and m_wb_ack to sn_wb_ack.
REQ-015 SHALL force m_wb_stb=0 and sn_wb_stall=1 for the owner when outstanding == MAX_OUTSTANDING (unless an ack arrives that cycle: still stall, no look-ahead).
REQ-016 SHALL in OWNn, when sn_wb_cyc=0: go to IDLE if outstanding==0 (counting the current-cycle ack), else to DRAIN; m_wb_stb=0 in that cycle.
REQ-017 SHALL in DRAIN keep m_wb_cyc=1, m_wb_stb=0, route m_wb_ack to the former owner (last_grant), and go to IDLE when outstanding reaches 0.
REQ-018 SHALL drive non-owner sn_wb_stall=1 and sn_wb_ack=0 in every state; in IDLE both requesters see stall=1, ack=0.
REQ-019 SHALL broadcast m_wb_dat_s2m to both sn_wb_dat_s2m unconditionally.
REQ-020 SHALL update outstanding: +1 on downstream accept (m_wb_stb & !m_wb_stall), -1 on m_wb_ack, unchanged when both same cycle.
REQ-021 SHALL on m_wb_ack with outstanding==0 not decrement, not forward the ack, and set err_spurious_ack=1 until reset.
REQ-022 SHALL give first-request latency of one cycle: cyc asserted in cycle N with IDLE gives m_wb_stb visible in cycle N+1.
REQ-023 SHALL never re-arbitrate while a requester owns the bus or a drain is pending; an owner holding cyc may starve the other.
REQ-024 SHALL drive m_wb_cyc=0 and m_wb_stb=0 in IDLE.

Reset
REQ-025 SHALL on sresetn=0 at a clock edge set state=IDLE, outstanding=0, last_grant=1, err_spurious_ack=0, abandoning any in-flight transaction.
REQ-026 SHALL while state=IDLE (including reset) present m_wb_cyc=0, m_wb_stb=0, s0/s1_wb_stall=1, s0/s1_wb_ack=0.
REQ-027 SHALL give requester 0 the first tie after reset.

Verification
REQ-028 SHALL verify reset tie: both cyc rise same cycle after reset -> OWN0 next cycle; after s0 drops cyc with 0 outstanding -> IDLE then OWN1; third tie -> OWN0.
REQ-029 SHALL verify cap: MAX_OUTSTANDING=4, slave stall=0, no ack, s0 stb held 6 cycles -> exactly 4 accepts, s0_wb_stall=1 thereafter; one ack -> one further accept.
REQ-030 SHALL verify drain: s1 issues 3 writes, drops cyc before any ack -> DRAIN, m_wb_cyc=1, 3 acks delivered to s1 only, IDLE after third; s0 request meanwhile stalled.
REQ-031 SHALL verify simultaneous accept+ack at outstanding=2 -> outstanding stays 2.
REQ-032 SHALL verify spurious ack in IDLE -> no sn_wb_ack pulse, err_spurious_ack=1 until sresetn=0.
REQ-033 SHALL verify mid-transaction reset: sresetn=0 in OWN0 with outstanding=3 -> next cycle IDLE, outstanding=0, m_wb_cyc=0.
